jump_fetch_ctrl: RTL and testbench

Fetch-side PC sequencer for the MIPS core. It owns the program counter and issues single-outstanding instruction-memory requests. It hands fetched instructions to decode with a valid/ready handshake and redirects the PC on J/JAL, JR and taken branches. J-type targets are formed internally as {pc_of_jump_plus4[31:28], index, 2'b00} by instantiating the existing jump shifter, so decode only forwards the raw 26-bit index.

---
 rtl/jump_fetch_ctrl.sv | 140 ++++++++++++++
 tb/tb_jump_fetch_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jump_fetch_ctrl.sv
// Fetch-side PC sequencer: single-outstanding imem fetch, decode handoff, J/JR/branch redirect.
// Define DELAY_SLOT_EN to honour the MIPS branch delay slot instead of flushing the next fetch.
module jump_shifter (
  input  logic [31:0] pc_plus4,
  input  logic [25:0] index,
  output logic [31:0] target
);
  assign target = {pc_plus4[31:28], index, 2'b00};
endmodule

module jump_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        if_ready,
  input  logic        redir_valid,
  input  logic [1:0]  redir_kind,
  input  logic [31:0] redir_pc,
  input  logic [25:0] redir_index,
  input  logic [31:0] redir_target,
  input  logic        redir_link,
  output logic        link_valid,
  output logic [31:0] link_addr,
  output logic        misalign
);
  localparam logic [1:0] BOOT = 2'd0, REQ = 2'd1, WAIT = 2'd2, HOLD = 2'd3;
  localparam logic [1:0] K_J = 2'b00, K_JR = 2'b01, K_RSVD = 2'b11;
`ifdef DELAY_SLOT_EN
  localparam logic [31:0] LINK_OFS = 32'd8;
`else
  localparam logic [31:0] LINK_OFS = 32'd4;
`endif

  logic [1:0]  state;
  logic [31:0] pc, fetch_pc, redir_pc4, jtarget, target;
  logic        discard, redir_act, accept, hshake;
`ifdef DELAY_SLOT_EN
  logic        pending;
  logic [31:0] pend_target;
`endif

  assign redir_pc4 = redir_pc + 32'd4;

  jump_shifter u_jshift (
    .pc_plus4 (redir_pc4),
    .index    (redir_index),
    .target   (jtarget)
  );

  assign target    = (redir_kind == K_J) ? jtarget : {redir_target[31:2], 2'b00};
  assign redir_act = redir_valid && (redir_kind != K_RSVD);
  assign imem_req  = (state == REQ);
  assign imem_addr = pc;
  assign accept    = imem_req && imem_ready;
  assign if_valid  = (state == HOLD);
  assign hshake    = if_valid && if_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= BOOT;
      pc       <= RESET_PC;
      fetch_pc <= '0;
      discard  <= 1'b0;
      if_instr <= '0;
      if_pc    <= '0;
`ifdef DELAY_SLOT_EN
      pending     <= 1'b0;
      pend_target <= '0;
`endif
    end else begin
      case (state)
        BOOT: state <= REQ;
        REQ: if (accept) begin
          pc       <= pc + 32'd4;
          fetch_pc <= pc;
          state    <= WAIT;
        end
        WAIT: if (imem_rvalid) begin
          if (discard) begin
            discard <= 1'b0;
            state   <= REQ;
          end else begin
            if_instr <= imem_rdata;
            if_pc    <= fetch_pc;
            state    <= HOLD;
          end
        end
        HOLD: if (hshake) state <= REQ;
        default: state <= BOOT;
      endcase
`ifdef DELAY_SLOT_EN
      // Target waits until the delay-slot instruction has been handed to decode.
      if (redir_act) begin
        pending     <= 1'b1;
        pend_target <= target;
      end
      if (hshake && (pending || redir_act)) begin
        pc      <= redir_act ? target : pend_target;
        pending <= 1'b0;
      end
`else
      // Redirect overrides the sequential update; an in-flight fetch becomes wrong-path.
      if (redir_act) begin
        pc <= target;
        case (state)
          REQ:  discard <= accept;
          WAIT: begin
            discard <= !imem_rvalid;
            if (imem_rvalid) state <= REQ;
          end
          HOLD: state <= REQ;
          default: ;
        endcase
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      link_valid <= 1'b0;
      link_addr  <= '0;
      misalign   <= 1'b0;
    end else begin
      link_valid <= redir_valid && (redir_kind == K_J) && redir_link;
      if (redir_valid && (redir_kind == K_J) && redir_link)
        link_addr <= redir_pc + LINK_OFS;
      misalign <= redir_valid && (redir_kind == K_JR) && (redir_target[1:0] != 2'b00);
    end
  end
endmodule

// File: tb/tb_jump_fetch_ctrl.sv
// Directed bench for jump_fetch_ctrl: expected deliveries are queued by the stimulus and
// popped by a decode-side monitor on every handshake; a small memory model answers fetches.
module tb_jump_fetch_ctrl;
  localparam logic [31:0] RST_PC = 32'h0040_0000;
`ifdef DELAY_SLOT_EN
  localparam logic [31:0] LINK_OFS_E = 32'd8;
  localparam logic [31:0] JR_NOW_E   = 32'h0000_0804;
  localparam logic [31:0] BR_VALID_E = 32'd1;
`else
  localparam logic [31:0] LINK_OFS_E = 32'd4;
  localparam logic [31:0] JR_NOW_E   = 32'h0000_3000;
  localparam logic [31:0] BR_VALID_E = 32'd0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req, imem_ready, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        if_valid, if_ready;
  logic [31:0] if_instr, if_pc;
  logic        redir_valid, redir_link;
  logic [1:0]  redir_kind;
  logic [31:0] redir_pc, redir_target;
  logic [25:0] redir_index;
  logic        link_valid, misalign;
  logic [31:0] link_addr;

  logic        mem_rv = 1'b0, inj_rv;
  logic [31:0] mem_rd = '0;
  int          mem_lat;
  assign imem_rvalid = mem_rv | inj_rv;
  assign imem_rdata  = inj_rv ? 32'hDEAD_BEEF : mem_rd;

  typedef struct packed { logic [31:0] pc; logic [31:0] instr; } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  int   hs_cyc[$];
  int   checks = 0, failures = 0, hs_count = 0, cyc = 0;

  jump_fetch_ctrl #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_ready(if_ready),
    .redir_valid(redir_valid), .redir_kind(redir_kind), .redir_pc(redir_pc),
    .redir_index(redir_index), .redir_target(redir_target), .redir_link(redir_link),
    .link_valid(link_valid), .link_addr(link_addr), .misalign(misalign)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5C3_1E00;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tmo(input string nm);
    checks++;
    failures++;
    $display("FAIL %s: timeout waiting for DUT", nm);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] pc);
    exp_t e;
    e.pc    = pc;
    e.instr = mem_word(pc);
    exp_q.push_back(e);
  endtask

  task automatic wait_valid(input string nm);
    int n = 0;
    while (!if_valid && n < 40) begin tick(); n++; end
    if (!if_valid) tmo(nm);
  endtask

  task automatic take(input string nm);
    wait_valid(nm);
    if_ready = 1'b1;
    tick();
    if_ready = 1'b0;
  endtask

  task automatic wait_req(input string nm, input logic [31:0] exp_addr);
    int n = 0;
    while (!imem_req && n < 40) begin tick(); n++; end
    if (!imem_req) tmo(nm);
    else chk(nm, imem_addr, exp_addr);
  endtask

  task automatic pulse_redir(input logic [1:0] k, input logic [31:0] rpc, input logic [25:0] idx,
                             input logic [31:0] tgt, input logic lnk);
    redir_valid = 1'b1; redir_kind = k; redir_pc = rpc;
    redir_index = idx; redir_target = tgt; redir_link = lnk;
    tick();
    redir_valid = 1'b0; redir_link = 1'b0;
  endtask

  // Memory: answers an accepted fetch mem_lat cycles later; reset kills the pending reply.
  initial begin
    int cnt = 0;
    logic [31:0] ma = '0;
    forever begin
      @(negedge clk);
      if (reset) cnt = 0;
      else if (imem_req && imem_ready) begin cnt = mem_lat; ma = imem_addr; end
      @(posedge clk);
      #1;
      mem_rv = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin mem_rv = 1'b1; mem_rd = mem_word(ma); end
      end
    end
  end

  // Decode-side monitor; in the flush build a handshake coincident with a redirect is not one.
  initial begin
    forever begin
      @(negedge clk);
`ifdef DELAY_SLOT_EN
      if (!reset && if_valid && if_ready) begin
`else
      if (!reset && if_valid && if_ready && !(redir_valid && redir_kind != 2'b11)) begin
`endif
        hs_count++;
        hs_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_delivery: got pc %h instr %h expected none", if_pc, if_instr);
        end else begin
          mon_e = exp_q.pop_front();
          chk("deliver_pc", if_pc, mon_e.pc);
          chk("deliver_instr", if_instr, mon_e.instr);
        end
      end
    end
  end

  initial begin
    int n;
    int t0;
    reset = 1'b1; if_ready = 1'b1; imem_ready = 1'b1; inj_rv = 1'b0; mem_lat = 1;
    redir_valid = 1'b0; redir_kind = 2'b00; redir_pc = '0; redir_index = '0;
    redir_target = '0; redir_link = 1'b0;
    repeat (3) tick();
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, RST_PC);
    chk("rst_if_valid", if_valid, 0);
    chk("rst_if_instr", if_instr, 0);
    chk("rst_if_pc", if_pc, 0);
    chk("rst_link_valid", link_valid, 0);
    chk("rst_link_addr", link_addr, 0);
    chk("rst_misalign", misalign, 0);

    // Sequential fetch with zero-wait memory and decode always ready.
    for (int i = 0; i < 3; i++) push(RST_PC + 32'(4 * i));
    reset = 1'b0;
    t0 = cyc;
    chk("boot_no_req", imem_req, 0);
    tick();
    chk("first_req", imem_req, 1);
    chk("first_addr", imem_addr, RST_PC);
    n = 0;
    while (hs_count < 3 && n < 40) begin tick(); n++; end
    if (hs_count < 3) tmo("seq_deliver");
    if_ready = 1'b0;
    chk("first_deliv_cyc", hs_cyc[0] - t0, 3);
    chk("third_deliv_cyc", hs_cyc[2] - t0, 9);

    // J in HOLD with a coincident if_ready.
    wait_valid("hold_40000c");
`ifdef DELAY_SLOT_EN
    push(RST_PC + 32'd12);
`endif
    if_ready = 1'b1;
    pulse_redir(2'b00, 32'h1000_0010, 26'h000_0100, 32'h0, 1'b0);
    if_ready = 1'b0;
    chk("j_if_valid", if_valid, 0);
    chk("j_req", imem_req, 1);
    chk("j_addr", imem_addr, 32'h1000_0400);
    chk("j_no_link", link_valid, 0);
    push(32'h1000_0400);
    take("j_deliver");

    // JAL while the fetch of 0x10000404 is outstanding.
    mem_lat = 3;
    tick();
    pulse_redir(2'b00, 32'h0040_0020, 26'h000_0200, 32'h0, 1'b1);
    chk("jal_link_valid", link_valid, 1);
    chk("jal_link_addr", link_addr, 32'h0040_0020 + LINK_OFS_E);
    tick();
    chk("jal_link_pulse", link_valid, 0);
`ifdef DELAY_SLOT_EN
    push(32'h1000_0404);
    take("jal_delay_slot");
`endif
    wait_req("jal_target", 32'h0000_0800);
    mem_lat = 1;
    push(32'h0000_0800);
    take("jal_deliver");

    // Misaligned JR while REQ is stalled by memory.
    imem_ready = 1'b0;
    pulse_redir(2'b01, 32'h0000_0900, 26'h0, 32'h0000_3003, 1'b0);
    chk("jr_misalign", misalign, 1);
    chk("jr_addr_now", imem_addr, JR_NOW_E);
    tick();
    chk("jr_misalign_pulse", misalign, 0);
    imem_ready = 1'b1;
`ifdef DELAY_SLOT_EN
    push(32'h0000_0804);
    take("jr_delay_slot");
`endif
    wait_req("jr_target", 32'h0000_3000);
    push(32'h0000_3000);
    take("jr_deliver");

    // Reserved kind is ignored; branch target low bits are masked without misalign.
    wait_valid("hold_3004");
    pulse_redir(2'b11, 32'h0, 26'h0, 32'h0000_5553, 1'b0);
    chk("rsvd_if_valid", if_valid, 1);
    chk("rsvd_if_pc", if_pc, 32'h0000_3004);
    chk("rsvd_no_misalign", misalign, 0);
    pulse_redir(2'b10, 32'h0000_0100, 26'h0, 32'h0000_0202, 1'b0);
    chk("br_if_valid", if_valid, BR_VALID_E);
    chk("br_no_misalign", misalign, 0);
`ifdef DELAY_SLOT_EN
    push(32'h0000_3004);
    take("br_delay_slot");
`endif
    wait_req("br_target", 32'h0000_0200);
    push(32'h0000_0200);
    take("br_deliver");

    // PC increment wraps at the top of the address space.
    imem_ready = 1'b0;
    pulse_redir(2'b01, 32'h0000_0200, 26'h0, 32'hFFFF_FFFC, 1'b0);
    chk("jr_aligned_no_misalign", misalign, 0);
    imem_ready = 1'b1;
`ifdef DELAY_SLOT_EN
    push(32'h0000_0204);
    take("wrap_delay_slot");
`endif
    wait_req("wrap_target", 32'hFFFF_FFFC);
    push(32'hFFFF_FFFC);
    take("wrap_deliver");
    wait_req("pc_wrap", 32'h0000_0000);

    // Reset in WAIT, then stale rvalid right after release.
    mem_lat = 10;
    tick();
    chk("pre_reset_wait", imem_req, 0);
    reset = 1'b1;
    tick();
    chk("mid_rst_req", imem_req, 0);
    chk("mid_rst_addr", imem_addr, RST_PC);
    chk("mid_rst_if_pc", if_pc, 0);
    chk("mid_rst_if_instr", if_instr, 0);
    chk("mid_rst_link_addr", link_addr, 0);
    chk("mid_rst_link_valid", link_valid, 0);
    reset = 1'b0;
    inj_rv = 1'b1;
    chk("post_rst_boot", imem_req, 0);
    tick();
    chk("post_rst_req", imem_req, 1);
    chk("post_rst_addr", imem_addr, RST_PC);
    chk("post_rst_if_valid", if_valid, 0);
    mem_lat = 1;
    tick();
    inj_rv = 1'b0;
    chk("stale_ignored", if_valid, 0);
    push(RST_PC);
    take("restart_deliver");

    repeat (3) tick();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
